hazard_control_unit: RTL
========================

Name: hazard_control_unit

Overview:
- Backward-flowing control for the 5-stage pipeline: it takes register-use and destination information from the ID, EX and MEM stages and drives stall, bubble and flush controls back into the IF stage, the IF/ID register and the ID/EX register.
- It is the reverse-direction counterpart of the forward IF->ID->EX->MEM->WB datapath flow.
- It keeps 32-bit stall and flush event counters for the seven-segment debug display.

Parameters:
- FORWARDING, 0, 1 = EX/MEM forwarding exists, so only load-use in EX stalls; 0 = no forwarding, so every RAW hazard stalls.
- LOAD_STALL_CYCLES, 2, stall length for a hazard against the EX stage when FORWARDING=0. Legal values 1..3. When FORWARDING=1 the length is fixed at 1.

Ports:
- Clk  in  1  pipeline clock (ClkOut domain)
- Rst  in  1  synchronous, active-high reset
- Hold  in  1  external freeze (memory wait); freezes all pipeline registers
- ID_Rs, ID_Rt  in  5 each  source register indices of the instruction in ID
- ID_UsesRs, ID_UsesRt  in  1 each  the ID instruction actually reads that source
- ID_Jump  in  1  jump resolved in ID
- EX_Rd  in  5  destination register of the instruction in EX
- EX_RegWrite, EX_MemRead  in  1 each  control bits of the EX instruction
- EX_BranchTaken  in  1  branch resolved taken in EX
- MEM_Rd  in  5  destination register of the instruction in MEM
- MEM_RegWrite  in  1  MEM-stage write enable
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID register load enable
- IFIDFlush  out  1  clear IF/ID to a NOP
- IDEXBubble  out  1  load a NOP into ID/EX
- StallCount  out  32  cycles in which PCWrite=0 and Hold=0
- FlushCount  out  32  cycles in which IFIDFlush=1

Behaviour:
- Outputs are Mealy: decoded combinationally from state and inputs in the same cycle.
- The state register and the counters update on the rising edge of Clk.
- Reset values: state RUN, remaining-stall counter 0, StallCount=0, FlushCount=0. During reset the outputs are PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0.
- Match definitions:
  - matchEX = EX_RegWrite & EX_Rd!=0 & ((ID_UsesRs & ID_Rs==EX_Rd) | (ID_UsesRt & ID_Rt==EX_Rd))
  - matchMEM is the same test using MEM_Rd and MEM_RegWrite.
  - Register $0 never causes a hazard.
- Hazard detection:
  - FORWARDING=1: hazard = matchEX & EX_MemRead, stall length 1.
  - FORWARDING=0: matchEX gives stall length LOAD_STALL_CYCLES. Otherwise matchMEM gives stall length 1.
- FSM states:
  - RUN: no action required.
  - STALL: holds a 2-bit remaining counter.
- RUN:
  - If a hazard is detected: PCWrite=0, IFIDWrite=0, IDEXBubble=1.
  - If the length is >1: go to STALL with remaining = len-1. Otherwise stay in RUN.
- STALL:
  - Outputs as above; hazard inputs are ignored.
  - Decrement remaining each cycle; return to RUN when remaining==1.
- Priority, highest first: Rst > Hold > EX_BranchTaken > stall > ID_Jump.
- EX_BranchTaken, in any state:
  - Outputs: IFIDFlush=1, IDEXBubble=1, PCWrite=1, IFIDWrite=1.
  - It aborts any stall in progress: next state RUN, remaining=0.
- ID_Jump:
  - Honoured only when there is no stall and no branch. IFIDFlush=1, PCWrite=1.
  - A jump coinciding with a stall is deferred: the jump stays in ID and is re-presented after the stall.
- Hold=1:
  - Outputs PCWrite=0, IFIDWrite=0, IFIDFlush=0, IDEXBubble=0.
  - State, remaining count and counters are all frozen.
- Counters wrap modulo 2^32. StallCount excludes Hold cycles.
- Rst asserted mid-stall returns the block to RUN on the next edge.

Decomposition:
- Shared package hazard_pkg holds:
  - state encoding: RUN=1'b0, STALL=1'b1
  - REG_IDX_W=5 and the ZERO_REG constant
  - the FORWARDING default
- One sub-module, event_counter32: synchronous reset, enable, wrap. It is instantiated twice, for StallCount and FlushCount.

Test Plan:
1. FORWARDING=0, LOAD_STALL_CYCLES=2; EX_Rd=5, EX_RegWrite=1, ID_Rs=5, ID_UsesRs=1 for one cycle, then EX fields cleared -> PCWrite=0 and IDEXBubble=1 for exactly 2 cycles, then PCWrite=1; StallCount=2.
2. FORWARDING=1; EX_MemRead=1, EX_Rd=8, ID_Rt=8, ID_UsesRt=1 -> 1-cycle stall. Repeat with EX_MemRead=0 -> no stall.
3. Hazard on register 0 (EX_Rd=0, ID_Rs=0, EX_RegWrite=1) -> no stall; StallCount stays 0.
4. EX_BranchTaken=1 in the second cycle of a 2-cycle stall -> that cycle IFIDFlush=1, IDEXBubble=1, PCWrite=1; next cycle state RUN; FlushCount=1.
5. ID_Jump=1 together with a matchMEM hazard (FORWARDING=0) -> stall cycle with IFIDFlush=0; next cycle IFIDFlush=1.
6. Hold=1 for 3 cycles during STALL -> all outputs frozen per the Hold rule, counters unchanged; the stall resumes with the same remaining count after Hold=0. Rst=1 mid-stall -> RUN and counters 0 on the next edge.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared definitions for the pipeline hazard control block:
//               FSM state encoding, register index width, the hard-wired
//               zero register and the default forwarding configuration.
// Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

  localparam int                   REG_IDX_W          = 5;
  localparam logic [REG_IDX_W-1:0] ZERO_REG           = '0;
  localparam int                   FORWARDING_DEFAULT = 0;

  // FSM state encoding
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  // True when a writing stage targets a register the ID instruction reads.
  // The zero register is never a real dependency.
  function automatic logic dep_match(
    input logic                 wr_en,
    input logic [REG_IDX_W-1:0] dst,
    input logic                 uses_rs,
    input logic [REG_IDX_W-1:0] rs,
    input logic                 uses_rt,
    input logic [REG_IDX_W-1:0] rt
  );
    return wr_en && (dst != ZERO_REG) &&
           ((uses_rs && (rs == dst)) || (uses_rt && (rt == dst)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/event_counter32.sv
`default_nettype none
// ============================================================================
// Module      : event_counter32
// Description : 32-bit event counter with synchronous reset and enable.
//               Wraps modulo 2^32.
// Ports       : clk      - clock
//               rst      - synchronous active-high reset
//               i_en     - count this cycle
//               o_count  - current count
// Revision    : 1.0  initial release
// ============================================================================
module event_counter32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 32'd0;
    end else if (i_en) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_control_unit
// Description : Backward-flowing pipeline control. Detects RAW hazards
//               between ID and the EX/MEM stages, and drives stall, bubble
//               and flush controls into IF, IF/ID and ID/EX. Counts stall
//               and flush cycles for the debug display.
// Ports       : Clk, Rst          - clock, synchronous active-high reset
//               Hold              - external freeze of the whole pipeline
//               ID_*              - source regs of the ID instruction, jump
//               EX_*              - EX destination/control, branch taken
//               MEM_*             - MEM destination/write enable
//               PCWrite/IFIDWrite - load enables (Mealy)
//               IFIDFlush         - squash IF/ID
//               IDEXBubble        - insert NOP into ID/EX
//               StallCount        - cycles with PCWrite=0 and Hold=0
//               FlushCount        - cycles with IFIDFlush=1
// Revision    : 1.0  initial release
// ============================================================================
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int FORWARDING        = FORWARDING_DEFAULT,
  parameter int LOAD_STALL_CYCLES = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Hold,
  input  logic [REG_IDX_W-1:0] ID_Rs,
  input  logic [REG_IDX_W-1:0] ID_Rt,
  input  logic                 ID_UsesRs,
  input  logic                 ID_UsesRt,
  input  logic                 ID_Jump,
  input  logic [REG_IDX_W-1:0] EX_Rd,
  input  logic                 EX_RegWrite,
  input  logic                 EX_MemRead,
  input  logic                 EX_BranchTaken,
  input  logic [REG_IDX_W-1:0] MEM_Rd,
  input  logic                 MEM_RegWrite,
  output logic                 PCWrite,
  output logic                 IFIDWrite,
  output logic                 IFIDFlush,
  output logic                 IDEXBubble,
  output logic [31:0]          StallCount,
  output logic [31:0]          FlushCount
);

  localparam logic [1:0] C_EX_LEN = LOAD_STALL_CYCLES[1:0];

  logic [0:0] r_state;
  logic [1:0] r_remain;
  logic [0:0] w_state_nxt;
  logic [1:0] w_remain_nxt;

  logic       w_match_ex;
  logic       w_match_mem;
  logic       w_hazard;
  logic [1:0] w_len;
  logic       w_stall;

  assign w_match_ex  = dep_match(EX_RegWrite, EX_Rd, ID_UsesRs, ID_Rs,
                                 ID_UsesRt, ID_Rt);
  assign w_match_mem = dep_match(MEM_RegWrite, MEM_Rd, ID_UsesRs, ID_Rs,
                                 ID_UsesRt, ID_Rt);

  // With forwarding only a load in EX cannot be bypassed; without it every
  // dependency stalls, EX-stage ones for longer than MEM-stage ones.
  always_comb begin
    w_hazard = 1'b0;
    w_len    = 2'd1;
    if (FORWARDING != 0) begin
      w_hazard = w_match_ex && EX_MemRead;
    end else if (w_match_ex) begin
      w_hazard = 1'b1;
      w_len    = C_EX_LEN;
    end else if (w_match_mem) begin
      w_hazard = 1'b1;
    end
  end

  // Hazard inputs are ignored while a multi-cycle stall is being served.
  assign w_stall = (r_state == ST_STALL) || w_hazard;

  // Mealy outputs, priority Rst > Hold > branch > stall > jump
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;
    if (Rst) begin
      PCWrite = 1'b1;
    end else if (Hold) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end else if (EX_BranchTaken) begin
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
    end else if (w_stall) begin
      // A coincident jump stays in ID and is re-presented after the stall
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end else if (ID_Jump) begin
      IFIDFlush = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;
    if (Hold) begin
      w_state_nxt  = r_state;
      w_remain_nxt = r_remain;
    end else if (EX_BranchTaken) begin
      w_state_nxt  = ST_RUN;
      w_remain_nxt = 2'd0;
    end else if (r_state == ST_STALL) begin
      if (r_remain == 2'd1) begin
        w_state_nxt  = ST_RUN;
        w_remain_nxt = 2'd0;
      end else begin
        w_remain_nxt = r_remain - 2'd1;
      end
    end else if (w_hazard && (w_len > 2'd1)) begin
      w_state_nxt  = ST_STALL;
      w_remain_nxt = w_len - 2'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state  <= ST_RUN;
      r_remain <= 2'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_remain <= w_remain_nxt;
    end
  end

  event_counter32 u_stall_cnt (
    .clk     (Clk),
    .rst     (Rst),
    .i_en    (!PCWrite && !Hold),
    .o_count (StallCount)
  );

  event_counter32 u_flush_cnt (
    .clk     (Clk),
    .rst     (Rst),
    .i_en    (IFIDFlush),
    .o_count (FlushCount)
  );

endmodule
`default_nettype wire
